// File: rtl/cfg_pkg.sv
// Shared types and constants for the SelfWrite configuration streamer.
// Word geometry, default timing and the FSM state encoding live here.
package cfg_pkg;

  localparam int CFG_WORD_W         = 32;
  localparam int CFG_BYTES_PER_WORD = 4;
  localparam int CFG_SETUP_CYCLES   = 2;
  localparam int CFG_HOLD_CYCLES    = 2;
  localparam int CFG_MAX_WORDS      = 5000;
  localparam int CFG_CNT_W          = 13;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_COLLECT,
    CFG_SETUP,
    CFG_STROBE,
    CFG_HOLD,
    CFG_DONE
  } cfg_wr_state_t;

  // Width of a counter that must reach max(setup, hold) - 1.
  function automatic int cfg_dly_w(input int setup_c, input int hold_c);
    int m;
    m = (setup_c > hold_c) ? setup_c : hold_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cfg_byte_packer.sv
// Packs four bytes big-endian into one word; byte 0 lands in [31:24].
// word_out already contains the byte being accepted, so the caller can capture it on word_full.
module cfg_byte_packer
  import cfg_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [CFG_WORD_W-1:0] word_out,
  output logic                  word_full
);

  logic [1:0]            idx;
  logic [CFG_WORD_W-1:0] slots;

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    word_out = slots;
    unique case (idx)
      2'd0: word_out[31:24] = byte_in;
      2'd1: word_out[23:16] = byte_in;
      2'd2: word_out[15:8]  = byte_in;
      2'd3: word_out[7:0]   = byte_in;
    endcase
    word_full = accept && (idx == 2'd3);
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear) begin
      idx   <= '0;
      slots <= '0;
    end else if (accept) begin
      idx   <= idx + 2'd1;
      slots <= word_out;
    end
  end

endmodule

// File: rtl/cfg_self_write_streamer.sv
// SelfWrite initiator: collects bitstream bytes into words and issues each word with a
// one-cycle strobe framed by setup/hold spacing. All outputs come straight from flops.
module cfg_self_write_streamer
  import cfg_pkg::*;
#(
  parameter int SETUP_CYCLES = CFG_SETUP_CYCLES,
  parameter int HOLD_CYCLES  = CFG_HOLD_CYCLES,
  parameter int MAX_WORDS    = CFG_MAX_WORDS,
  parameter int CNT_W        = CFG_CNT_W
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [CFG_WORD_W-1:0] SelfWriteData,
  output logic                  SelfWriteStrobe,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      words_written
);

  localparam int               DLY_W      = cfg_dly_w(SETUP_CYCLES, HOLD_CYCLES);
  localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(SETUP_CYCLES - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WORDS_LAST = CNT_W'(MAX_WORDS);

  cfg_wr_state_t         state, state_nxt;
  logic [DLY_W-1:0]      dly_cnt, dly_nxt;
  logic                  accept, word_full, pack_clear, active, load_start;
  logic [CFG_WORD_W-1:0] packed_word;
  cfg_wr_state_t         after_write;

  // byte_ready is a registered copy of (state == COLLECT), so it doubles as the accept gate.
  assign accept     = byte_valid && byte_ready;
  assign active     = state inside {CFG_COLLECT, CFG_SETUP, CFG_STROBE, CFG_HOLD};
  assign load_start = (state inside {CFG_IDLE, CFG_DONE}) && (state_nxt == CFG_COLLECT);
  assign pack_clear = load_start;
  // words_written already counts the current strobe by the time STROBE/HOLD decide.
  assign after_write = (words_written == WORDS_LAST) ? CFG_DONE : CFG_COLLECT;

  cfg_byte_packer u_packer (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (pack_clear),
    .accept    (accept),
    .byte_in   (byte_data),
    .word_out  (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    unique case (state)
      CFG_IDLE, CFG_DONE: begin
        if (start && !abort) state_nxt = CFG_COLLECT;
      end
      CFG_COLLECT: begin
        if (word_full) begin
          state_nxt = CFG_SETUP;
          dly_nxt   = '0;
        end
      end
      CFG_SETUP: begin
        if (dly_cnt == SETUP_LAST) state_nxt = CFG_STROBE;
        else                       dly_nxt   = dly_cnt + DLY_W'(1);
      end
      CFG_STROBE: begin
        dly_nxt   = '0;
        state_nxt = (HOLD_CYCLES > 0) ? CFG_HOLD : after_write;
      end
      CFG_HOLD: begin
        if (dly_cnt == HOLD_LAST) state_nxt = after_write;
        else                      dly_nxt   = dly_cnt + DLY_W'(1);
      end
      default: state_nxt = CFG_IDLE;
    endcase
    if (abort && active) state_nxt = CFG_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state           <= CFG_IDLE;
      dly_cnt         <= '0;
      byte_ready      <= 1'b0;
      SelfWriteData   <= '0;
      SelfWriteStrobe <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      words_written   <= '0;
    end else begin
      state           <= state_nxt;
      dly_cnt         <= dly_nxt;
      byte_ready      <= (state_nxt == CFG_COLLECT);
      SelfWriteStrobe <= (state_nxt == CFG_STROBE);
      busy            <= state_nxt inside {CFG_COLLECT, CFG_SETUP, CFG_STROBE, CFG_HOLD};
      done            <= (state_nxt == CFG_DONE);
      if (state == CFG_COLLECT && state_nxt == CFG_SETUP) SelfWriteData <= packed_word;
      if (load_start)                   words_written <= '0;
      else if (state_nxt == CFG_STROBE) words_written <= words_written + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cfg_self_write_streamer.sv
// Bench for cfg_self_write_streamer: random byte streams against a byte-queue packing model,
// with a word log captured at every SelfWriteStrobe.
module tb_cfg_self_write_streamer;
  import cfg_pkg::*;

  localparam int MAXW   = 3;
  localparam int SETUP  = CFG_SETUP_CYCLES;
  localparam int HOLD   = CFG_HOLD_CYCLES;
  localparam int CW     = CFG_CNT_W;
  localparam int PERIOD = CFG_BYTES_PER_WORD + SETUP + 1 + HOLD;

  logic          CLK = 1'b0;
  logic          reset, start, abort, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, SelfWriteStrobe, busy, done;
  logic [31:0]   SelfWriteData;
  logic [CW-1:0] words_written;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] log_q[$];
  int          stb_cyc[$];
  int          chg_cyc[$];
  int          last_chg = 0;
  logic [31:0] prev_data = '0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_w[$];

  cfg_self_write_streamer #(
    .SETUP_CYCLES (SETUP),
    .HOLD_CYCLES  (HOLD),
    .MAX_WORDS    (MAXW),
    .CNT_W        (CW)
  ) dut (
    .CLK             (CLK),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .SelfWriteData   (SelfWriteData),
    .SelfWriteStrobe (SelfWriteStrobe),
    .busy            (busy),
    .done            (done),
    .words_written   (words_written)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (SelfWriteData !== prev_data) begin
      prev_data = SelfWriteData;
      last_chg  = cyc;
    end
    if (SelfWriteStrobe === 1'b1) begin
      log_q.push_back(SelfWriteData);
      stb_cyc.push_back(cyc);
      chg_cyc.push_back(last_chg);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    stb_cyc.delete();
    chg_cyc.delete();
    exp_bytes.delete();
    exp_w.delete();
  endtask

  // Reference: every 4 consecutive accepted bytes form one word, first byte most significant.
  function automatic void build_exp();
    exp_w.delete();
    for (int i = 0; i + 3 < exp_bytes.size(); i += 4)
      exp_w.push_back({exp_bytes[i], exp_bytes[i+1], exp_bytes[i+2], exp_bytes[i+3]});
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      step();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      acc = byte_ready;
      step();
      n++;
    end while (!acc && n < 200);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_byte_timeout byte_ready=%b want 1 within 200 cycles", byte_ready);
    end
    exp_bytes.push_back(b);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout done=%b want 1", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0;
    step();
    step();
    checks++;
    if ({byte_ready, SelfWriteStrobe, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {byte_ready, SelfWriteStrobe, busy, done});
    end
    checks++;
    if (SelfWriteData !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000000", SelfWriteData);
    end
    checks++;
    if (words_written !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", words_written);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] fixed [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_logs();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || words_written !== '0) begin
      failures++;
      $display("FAIL basic_start busy=%b count=%0d want busy=1 count=0", busy, words_written);
    end
    foreach (fixed[i]) send_byte(fixed[i], 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    wait_done("basic");
    build_exp();
    checks++;
    if (log_q.size() != exp_w.size()) begin
      failures++;
      $display("FAIL basic_strobes got=%0d want=%0d", log_q.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL basic_word%0d got=%h want=%h", i, log_q[i], exp_w[i]);
      end
    end
    checks++;
    if (words_written !== CW'(MAXW) || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end count=%0d busy=%b want count=%0d busy=0", words_written, busy, MAXW);
    end
    // start and abort together in DONE: abort wins, so the load does not restart.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_start_abort done=%b busy=%b want done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_timing();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4 * MAXW; i++) send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    wait_done("timing");
    build_exp();
    checks++;
    if (log_q.size() != MAXW) begin
      failures++;
      $display("FAIL timing_strobes got=%0d want=%0d", log_q.size(), MAXW);
    end
    for (int k = 0; k < log_q.size() && k < exp_w.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_w[k]) begin
        failures++;
        $display("FAIL timing_word%0d got=%h want=%h", k, log_q[k], exp_w[k]);
      end
      checks++;
      if (stb_cyc[k] - chg_cyc[k] != SETUP) begin
        failures++;
        $display("FAIL timing_setup%0d got=%0d want=%0d", k, stb_cyc[k] - chg_cyc[k], SETUP);
      end
      if (k > 0) begin
        checks++;
        if (stb_cyc[k] - stb_cyc[k-1] != PERIOD) begin
          failures++;
          $display("FAIL timing_spacing%0d got=%0d want=%0d", k, stb_cyc[k] - stb_cyc[k-1], PERIOD);
        end
        checks++;
        if (chg_cyc[k] - stb_cyc[k-1] != 1 + HOLD + CFG_BYTES_PER_WORD) begin
          failures++;
          $display("FAIL timing_hold%0d got=%0d want=%0d", k, chg_cyc[k] - stb_cyc[k-1],
                   1 + HOLD + CFG_BYTES_PER_WORD);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] nb;
    clear_logs();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    byte_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      checks++;
      if (byte_ready !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready_gap%0d got=%b want=1", g, byte_ready);
      end
    end
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    // Offer a byte through setup, strobe and hold: it must not be taken.
    nb = 8'($urandom);
    byte_valid = 1'b1;
    byte_data  = nb;
    for (int c = 0; c < SETUP + 1 + HOLD; c++) begin
      checks++;
      if (byte_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready_busy%0d got=%b want=0", c, byte_ready);
      end
      step();
    end
    send_byte(nb, 0);
    for (int i = 0; i < 4 * MAXW - 5; i++) send_byte(8'($urandom), $urandom_range(3, 0));
    byte_valid = 1'b0;
    wait_done("stall");
    build_exp();
    checks++;
    if (log_q.size() != exp_w.size()) begin
      failures++;
      $display("FAIL stall_strobes got=%0d want=%0d", log_q.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL stall_word%0d got=%h want=%h", i, log_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), $urandom_range(2, 0));
    void'(exp_bytes.pop_back());
    void'(exp_bytes.pop_back());
    byte_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, byte_ready, SelfWriteStrobe} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_flags busy/done/ready/strobe=%b want=0000",
               {busy, done, byte_ready, SelfWriteStrobe});
    end
    checks++;
    if (words_written !== CW'(2)) begin
      failures++;
      $display("FAIL abort_count got=%0d want=2", words_written);
    end
    for (int i = 0; i < 20; i++) step();
    build_exp();
    checks++;
    if (log_q.size() != 2) begin
      failures++;
      $display("FAIL abort_strobes got=%0d want=2", log_q.size());
    end
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL abort_word%0d got=%h want=%h", i, log_q[i], exp_w[i]);
      end
    end
    // A fresh load starts from byte 0 of a new word with the counter cleared.
    clear_logs();
    pulse_start();
    checks++;
    if (words_written !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_start count=%0d busy=%b want count=0 busy=1", words_written, busy);
    end
    for (int i = 0; i < 4 * MAXW; i++) send_byte(8'($urandom), $urandom_range(1, 0));
    byte_valid = 1'b0;
    wait_done("reload");
    build_exp();
    checks++;
    if (log_q.size() != exp_w.size() || words_written !== CW'(MAXW)) begin
      failures++;
      $display("FAIL reload_strobes got=%0d count=%0d want=%0d", log_q.size(), words_written, MAXW);
    end
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL reload_word%0d got=%h want=%h", i, log_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if ({byte_ready, SelfWriteStrobe, busy, done} !== 4'b0000 || SelfWriteData !== 32'h0 ||
        words_written !== '0) begin
      failures++;
      $display("FAIL midreset_outputs flags=%b data=%h count=%0d want all 0",
               {byte_ready, SelfWriteStrobe, busy, done}, SelfWriteData, words_written);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (log_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_strobes got=%0d want=0", log_q.size());
    end
    // start pulses while busy must not disturb the word stream.
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 0);
    byte_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 4 * MAXW - 6; i++) send_byte(8'($urandom), $urandom_range(2, 0));
    byte_valid = 1'b0;
    wait_done("busystart");
    build_exp();
    checks++;
    if (log_q.size() != exp_w.size() || words_written !== CW'(MAXW)) begin
      failures++;
      $display("FAIL busystart_strobes got=%0d count=%0d want=%0d", log_q.size(), words_written, MAXW);
    end
    for (int i = 0; i < exp_w.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL busystart_word%0d got=%h want=%h", i, log_q[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
